ae_sample_fill: RTL and testbench

- Front end of the acquisition engine. Takes raw 4-bit signed I/Q ADC samples and rate-converts them with a 32-bit NCO integrate-and-dump.
- Requantises each dump to a 4-bit sign/magnitude I/Q sample and drives the AE buffer write side (sample_in/sample_valid/refill).
- Run control: start / abort / done, with buffer-full termination.

---
 rtl/ae_sample_fill.sv | 250 +++++++++++++++++++++++++
 tb/tb_ae_sample_fill.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ae_sample_fill.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ae_sample_fill
//
// Acquisition-engine front end. Raw 4-bit signed I/Q ADC samples are
// rate-converted by a RATE_WIDTH-bit NCO integrate-and-dump. Each dump is
// requantised to a 4-bit sign/magnitude I/Q sample and written into the AE
// sample buffer. A small run-control FSM (IDLE/PREP/FILL/DONE) handles
// start, abort and termination when the buffer reports full.
//
// Optional build macro: AE_SAMPLE_FILL_STAT_EN
//   When defined, adds stat_total / stat_mag sample statistics outputs
//   used by the firmware mag_thr AGC loop. When undefined they are absent.
//
// Parameters
//   ACC_WIDTH   signed width of the I and Q integrators (saturating)
//   RATE_WIDTH  width of the NCO phase accumulator and rate_word
//
// Ports
//   clk           in   system clock
//   rst_b         in   asynchronous reset, active low
//   adc_i, adc_q  in   raw I/Q samples, two's complement, 4 bits
//   adc_valid     in   raw sample strobe
//   rate_word     in   NCO increment (out rate = adc rate * rate_word / 2^RATE_WIDTH)
//   mag_thr       in   unsigned magnitude threshold for the mag bits
//   start         in   pulse: (re)start a fill
//   abort         in   pulse: stop immediately (wins over start)
//   write_full    in   buffer full
//   refill        out  pulse to buffer: reset its write pointer
//   sample_in     out  {i_sign, i_mag, q_sign, q_mag}
//   sample_valid  out  sample_in valid for one cycle
//   busy          out  high while in PREP or FILL
//   done          out  one-cycle pulse when a fill ends on write_full
//   stat_total    out  (STAT_EN) emitted sample count, saturating
//   stat_mag      out  (STAT_EN) emitted i_mag+q_mag bit count, saturating
// -----------------------------------------------------------------------------
module ae_sample_fill #(
  parameter int ACC_WIDTH  = 8,
  parameter int RATE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [3:0]            adc_i,
  input  logic [3:0]            adc_q,
  input  logic                  adc_valid,
  input  logic [RATE_WIDTH-1:0] rate_word,
  input  logic [ACC_WIDTH-2:0]  mag_thr,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  write_full,
  output logic                  refill,
  output logic [3:0]            sample_in,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done
`ifdef AE_SAMPLE_FILL_STAT_EN
  ,
  output logic [15:0]           stat_total,
  output logic [15:0]           stat_mag
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Symmetric saturation limits: the integrators never hold -2^(ACC_WIDTH-1),
  // so the magnitude of any held value fits in ACC_WIDTH-1 bits.
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = (ACC_WIDTH+1)'(2**(ACC_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = -ACC_MAX;

  // Clamp a one-bit-wider sum into the symmetric integrator range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] v);
    logic signed [ACC_WIDTH:0] c;
    if (v > ACC_MAX)      c = ACC_MAX;
    else if (v < ACC_MIN) c = ACC_MIN;
    else                  c = v;
    return c[ACC_WIDTH-1:0];
  endfunction

  // Sign/magnitude requantisation of one rail: {sign, mag}.
  // Zero is positive and only reaches mag = 1 when the threshold is zero.
  function automatic logic [1:0] quant(input logic signed [ACC_WIDTH-1:0] s,
                                       input logic [ACC_WIDTH-2:0]        thr);
    logic                 neg;
    logic [ACC_WIDTH-1:0] mag_abs;
    neg     = s[ACC_WIDTH-1];
    mag_abs = neg ? unsigned'(-s) : unsigned'(s);
    return {neg, (mag_abs >= {1'b0, thr})};
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  logic   r_refill;
  logic   r_busy;
  logic   r_done;
  logic   r_sample_valid;
  logic [3:0] r_sample;

  logic [RATE_WIDTH-1:0]        r_phase;
  logic signed [ACC_WIDTH-1:0]  r_acc_i;
  logic signed [ACC_WIDTH-1:0]  r_acc_q;

  // Abort has priority over start; both override the per-state transitions.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else if (start) begin
      w_state_nxt = ST_PREP;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_PREP: w_state_nxt = ST_FILL;
        ST_FILL: if (write_full) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= ST_IDLE;
      r_refill <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_refill <= (w_state_nxt == ST_PREP);
      r_busy   <= (w_state_nxt == ST_PREP) || (w_state_nxt == ST_FILL);
      r_done   <= (w_state_nxt == ST_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // NCO and integrators (combinational sums for the current adc sample)
  // ---------------------------------------------------------------------------
  logic [RATE_WIDTH:0]         w_phase_sum;
  logic                        w_carry;
  logic signed [ACC_WIDTH:0]   w_adc_i_x;
  logic signed [ACC_WIDTH:0]   w_adc_q_x;
  logic signed [ACC_WIDTH:0]   w_sum_i;
  logic signed [ACC_WIDTH:0]   w_sum_q;
  logic signed [ACC_WIDTH-1:0] w_sat_i;
  logic signed [ACC_WIDTH-1:0] w_sat_q;
  logic [1:0]                  w_qi;
  logic [1:0]                  w_qq;
  logic                        w_accum;
  logic                        w_dump;

  assign w_phase_sum = {1'b0, r_phase} + {1'b0, rate_word};
  assign w_carry     = w_phase_sum[RATE_WIDTH];

  assign w_adc_i_x = {{(ACC_WIDTH-3){adc_i[3]}}, adc_i};
  assign w_adc_q_x = {{(ACC_WIDTH-3){adc_q[3]}}, adc_q};
  assign w_sum_i   = {r_acc_i[ACC_WIDTH-1], r_acc_i} + w_adc_i_x;
  assign w_sum_q   = {r_acc_q[ACC_WIDTH-1], r_acc_q} + w_adc_q_x;
  assign w_sat_i   = sat_acc(w_sum_i);
  assign w_sat_q   = sat_acc(w_sum_q);
  assign w_qi      = quant(w_sat_i, mag_thr);
  assign w_qq      = quant(w_sat_q, mag_thr);

  // Accumulate only while staying in FILL: any exit this cycle (abort,
  // restart, buffer full) drops the sample and any dump it would complete.
  assign w_accum = (r_state == ST_FILL) && adc_valid && !abort && !start && !write_full;
  assign w_dump  = w_accum && w_carry;

  // ---------------------------------------------------------------------------
  // Datapath registers: phase, integrators, dumped sample
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_phase        <= '0;
      r_acc_i        <= '0;
      r_acc_q        <= '0;
      r_sample       <= 4'd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_dump;
      if (r_state == ST_PREP) begin
        r_phase <= '0;
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (w_accum) begin
        r_phase <= w_phase_sum[RATE_WIDTH-1:0];
        if (w_carry) begin
          // The carrying sample is part of this dump; integration restarts
          // from zero with the next sample.
          r_acc_i  <= '0;
          r_acc_q  <= '0;
          r_sample <= {w_qi, w_qq};
        end else begin
          r_acc_i <= w_sat_i;
          r_acc_q <= w_sat_q;
        end
      end
    end
  end

  assign refill       = r_refill;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_in    = r_sample;
  assign sample_valid = r_sample_valid;

`ifdef AE_SAMPLE_FILL_STAT_EN
  // ---------------------------------------------------------------------------
  // Sample statistics for the AGC loop; updated together with each dump so
  // they are current in the same cycle sample_valid is presented.
  // ---------------------------------------------------------------------------
  logic [15:0] r_stat_total;
  logic [15:0] r_stat_mag;
  logic [15:0] w_stat_total_nxt;
  logic [1:0]  w_mag_bits;
  logic [16:0] w_stat_mag_sum;
  logic [15:0] w_stat_mag_nxt;

  assign w_stat_total_nxt = (r_stat_total == 16'hFFFF) ? r_stat_total : r_stat_total + 16'd1;
  assign w_mag_bits       = {1'b0, w_qi[0]} + {1'b0, w_qq[0]};
  assign w_stat_mag_sum   = {1'b0, r_stat_mag} + {15'd0, w_mag_bits};
  assign w_stat_mag_nxt   = w_stat_mag_sum[16] ? 16'hFFFF : w_stat_mag_sum[15:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_stat_total <= 16'd0;
      r_stat_mag   <= 16'd0;
    end else if (r_state == ST_PREP) begin
      r_stat_total <= 16'd0;
      r_stat_mag   <= 16'd0;
    end else if (w_dump) begin
      r_stat_total <= w_stat_total_nxt;
      r_stat_mag   <= w_stat_mag_nxt;
    end
  end

  assign stat_total = r_stat_total;
  assign stat_mag   = r_stat_mag;
`endif

endmodule

// File: tb/tb_ae_sample_fill.sv
`timescale 1ns/1ps
module tb_ae_sample_fill;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [3:0]  adc_i;
  logic [3:0]  adc_q;
  logic        adc_valid;
  logic [31:0] rate_word;
  logic [6:0]  mag_thr;
  logic        start;
  logic        abort;
  logic        write_full;
  logic        refill;
  logic [3:0]  sample_in;
  logic        sample_valid;
  logic        busy;
  logic        done;
`ifdef AE_SAMPLE_FILL_STAT_EN
  logic [15:0] stat_total;
  logic [15:0] stat_mag;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ae_sample_fill #(.ACC_WIDTH(8), .RATE_WIDTH(32)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .adc_i        (adc_i),
    .adc_q        (adc_q),
    .adc_valid    (adc_valid),
    .rate_word    (rate_word),
    .mag_thr      (mag_thr),
    .start        (start),
    .abort        (abort),
    .write_full   (write_full),
    .refill       (refill),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
`ifdef AE_SAMPLE_FILL_STAT_EN
    ,
    .stat_total   (stat_total),
    .stat_mag     (stat_mag)
`endif
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, then the PREP cycle; returns with the DUT in FILL.
  task automatic begin_fill();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #2;
    n_checks++; if (refill !== 1'b0) $display("FAIL reset_refill: got %b expected 0", refill); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sample_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (sample_in !== 4'b0000) $display("FAIL reset_sample: got %b expected 0000", sample_in); else n_pass++;
`ifdef AE_SAMPLE_FILL_STAT_EN
    n_checks++; if (stat_total !== 16'd0 || stat_mag !== 16'd0) $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_total, stat_mag); else n_pass++;
`endif
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  // start -> PREP with refill; adc samples during PREP must not count.
  task automatic test_prep();
    rate_word = 32'h8000_0000; mag_thr = 7'd3;
    adc_i = 4'd1; adc_q = 4'hD; adc_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (refill !== 1'b1) $display("FAIL prep_refill: got %b expected 1", refill); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL prep_busy: got %b expected 1", busy); else n_pass++;
    tick();
    n_checks++; if (refill !== 1'b0) $display("FAIL prep_refill_once: got %b expected 0", refill); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL fill_busy: got %b expected 1", busy); else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL prep_first_adc_valid: got %b expected 0", sample_valid); else n_pass++;
    tick();
    // I = +2 (< 3, mag 0), Q = -6 (mag 1); a PREP sample would make I = +3.
    n_checks++; if (sample_valid !== 1'b1) $display("FAIL prep_dump_valid: got %b expected 1", sample_valid); else n_pass++;
    n_checks++; if (sample_in !== 4'b0011) $display("FAIL prep_dump_sample: got %b expected 0011", sample_in); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // Every 2nd adc_valid dumps; gaps in adc_valid do not advance the NCO.
  task automatic test_basic();
    rate_word = 32'h8000_0000; mag_thr = 7'd2;
    adc_i = 4'd1; adc_q = 4'hD; adc_valid = 1'b1;
    begin_fill();
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL basic_adc1_valid: got %b expected 0", sample_valid); else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b1) $display("FAIL basic_adc2_valid: got %b expected 1", sample_valid); else n_pass++;
    n_checks++; if (sample_in !== 4'b0111) $display("FAIL basic_adc2_sample: got %b expected 0111", sample_in); else n_pass++;
    adc_i = 4'hE;
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL basic_adc3_valid: got %b expected 0", sample_valid); else n_pass++;
    adc_valid = 1'b0;
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL basic_gap_valid: got %b expected 0", sample_valid); else n_pass++;
    adc_valid = 1'b1; adc_i = 4'd1;
    tick();
    // I = -2 + 1 = -1 -> sign 1, mag 0; Q = -6 -> sign 1, mag 1.
    n_checks++; if (sample_valid !== 1'b1) $display("FAIL basic_adc4_valid: got %b expected 1", sample_valid); else n_pass++;
    n_checks++; if (sample_in !== 4'b1011) $display("FAIL basic_adc4_sample: got %b expected 1011", sample_in); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // 32 samples of +7 / -8 saturate at +127 / -127; both reach mag_thr = 127.
  task automatic test_saturation();
    int seen;
    rate_word = 32'h0800_0000; mag_thr = 7'd127;
    adc_i = 4'd7; adc_q = 4'h8; adc_valid = 1'b0;
    begin_fill();
    adc_valid = 1'b1;
    seen = 0;
    repeat (31) begin
      tick();
      if (sample_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL sat_early_dumps: got %0d expected 0", seen); else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b1) $display("FAIL sat_valid: got %b expected 1", sample_valid); else n_pass++;
    n_checks++; if (sample_in !== 4'b0111) $display("FAIL sat_sample: got %b expected 0111", sample_in); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // Wrapping rate word: one dump per sample after the first; zero sums.
  task automatic test_zero_and_single();
    rate_word = 32'hFFFF_FFFF; mag_thr = 7'd0;
    adc_i = 4'd0; adc_q = 4'd0; adc_valid = 1'b0;
    begin_fill();
    adc_valid = 1'b1;
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL wrap_first_valid: got %b expected 0", sample_valid); else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_in !== 4'b0101) $display("FAIL zero_thr0: got v=%b s=%b expected v=1 s=0101", sample_valid, sample_in); else n_pass++;
    mag_thr = 7'd1;
    tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_in !== 4'b0000) $display("FAIL zero_thr1: got v=%b s=%b expected v=1 s=0000", sample_valid, sample_in); else n_pass++;
    mag_thr = 7'd8; adc_i = 4'h8; adc_q = 4'd7;
    tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_in !== 4'b1100) $display("FAIL single_thr8: got v=%b s=%b expected v=1 s=1100", sample_valid, sample_in); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_rate_zero();
    int seen;
    rate_word = 32'd0; mag_thr = 7'd0;
    adc_i = 4'd3; adc_q = 4'd3; adc_valid = 1'b1;
    begin_fill();
    seen = 0;
    repeat (20) begin
      tick();
      if (sample_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rate0_dumps: got %0d expected 0", seen); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // write_full on the carrying sample: dump dropped, single done, back to IDLE.
  task automatic test_write_full();
    int seen;
    rate_word = 32'h8000_0000; mag_thr = 7'd2;
    adc_i = 4'd1; adc_q = 4'hD; adc_valid = 1'b1;
    begin_fill();
    tick();
    write_full = 1'b1;
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL full_valid: got %b expected 0", sample_valid); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL full_done: got %b expected 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL full_busy: got %b expected 0", busy); else n_pass++;
    write_full = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL full_done_once: got %b expected 0", done); else n_pass++;
    seen = 0;
    repeat (4) begin
      tick();
      if (sample_valid === 1'b1 || busy === 1'b1 || refill === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL full_idle_activity: got %0d expected 0", seen); else n_pass++;
  endtask

  task automatic test_abort_start();
    rate_word = 32'h8000_0000; mag_thr = 7'd2;
    adc_i = 4'd1; adc_q = 4'hD; adc_valid = 1'b1;
    begin_fill();
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || refill !== 1'b0 || done !== 1'b0 || sample_valid !== 1'b0)
      $display("FAIL abort_start: got busy=%b refill=%b done=%b valid=%b expected all 0", busy, refill, done, sample_valid); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || refill !== 1'b0 || sample_valid !== 1'b0)
      $display("FAIL abort_start_idle: got busy=%b refill=%b valid=%b expected all 0", busy, refill, sample_valid); else n_pass++;
  endtask

  // Restart on the carrying sample drops that dump and restarts the NCO.
  task automatic test_restart();
    rate_word = 32'h8000_0000; mag_thr = 7'd2;
    adc_i = 4'd1; adc_q = 4'hD; adc_valid = 1'b1;
    begin_fill();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (sample_valid !== 1'b0 || refill !== 1'b1) $display("FAIL restart_edge: got valid=%b refill=%b expected 0/1", sample_valid, refill); else n_pass++;
    tick();
    tick();
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL restart_adc1: got %b expected 0", sample_valid); else n_pass++;
    tick();
    n_checks++; if (sample_valid !== 1'b1 || sample_in !== 4'b0111) $display("FAIL restart_adc2: got v=%b s=%b expected v=1 s=0111", sample_valid, sample_in); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

`ifdef AE_SAMPLE_FILL_STAT_EN
  task automatic test_stats();
    rate_word = 32'h8000_0000; mag_thr = 7'd2;
    adc_i = 4'd1; adc_q = 4'd0; adc_valid = 1'b1;
    begin_fill();
    n_checks++; if (stat_total !== 16'd0 || stat_mag !== 16'd0) $display("FAIL stat_cleared: got %0d/%0d expected 0/0", stat_total, stat_mag); else n_pass++;
    repeat (20) tick();
    n_checks++; if (stat_total !== 16'd10) $display("FAIL stat_total: got %0d expected 10", stat_total); else n_pass++;
    n_checks++; if (stat_mag !== 16'd10) $display("FAIL stat_mag: got %0d expected 10", stat_mag); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    n_checks++; if (stat_total !== 16'd10 || stat_mag !== 16'd10) $display("FAIL stat_hold: got %0d/%0d expected 10/10", stat_total, stat_mag); else n_pass++;
    begin_fill();
    n_checks++; if (stat_total !== 16'd0 || stat_mag !== 16'd0) $display("FAIL stat_restart_clear: got %0d/%0d expected 0/0", stat_total, stat_mag); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask
`endif

  initial begin
    rst_b = 1'b0; adc_i = 4'd0; adc_q = 4'd0; adc_valid = 1'b0;
    rate_word = 32'd0; mag_thr = 7'd0;
    start = 1'b0; abort = 1'b0; write_full = 1'b0;
    test_reset();
    test_prep();
    test_basic();
    test_saturation();
    test_zero_and_single();
    test_rate_zero();
    test_write_full();
    test_abort_start();
    test_restart();
`ifdef AE_SAMPLE_FILL_STAT_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
